tick_nbit_cnt: RTL and testbench

Parametrised successor to the two-bit slow counter. A single-clock N-bit modulo counter advances on an internal prescaler tick (a clock-enable) rather than a derived slow clock. It supports up/down counting, synchronous parallel load, count enable and a wrap pulse. It drives board-level displays and LEDs from the 100 MHz system clock.

---
 rtl/tick_nbit_cnt.sv | 101 ++++++++++
 tb/tb_tick_nbit_cnt.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_nbit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tick_nbit_cnt
// Description : Single-clock N-bit modulo up/down counter. It advances on an
//               internal prescaler tick (a clock enable), not on a derived
//               clock. It has a synchronous clamped parallel load, a count
//               enable, and registered tick/wrap pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_nbit_cnt #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = 50000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             tick,
    output logic             wrap
);

    // Prescaler width is ceil(log2(DIV)), with a minimum of one bit.
    localparam int              c_PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

    logic             w_step;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_wrap;

    generate
        if (DIV == 1) begin : g_div_one
            // No prescaler is needed: every enabled cycle is a step.
            assign w_step = en;
        end else begin : g_div_n
            localparam logic [c_PW-1:0] c_DIV_LAST = c_PW'(DIV - 1);

            logic [c_PW-1:0] r_presc;

            // Prescaler: a load restarts it, and it holds its position while
            // en is low so that no step is lost or duplicated.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_presc <= '0;
                end else if (ld) begin
                    r_presc <= '0;
                end else if (en) begin
                    if (r_presc == c_DIV_LAST) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + c_PW'(1);
                    end
                end
            end

            assign w_step = en && (r_presc == c_DIV_LAST);
        end
    endgenerate

    // An out-of-range load value is clamped to the top of the count range.
    assign w_load_val = (d > c_MAX) ? c_MAX : d;

    // Counter update with priority load > step > hold. tick and wrap are
    // registered alongside Q so that they line up with the new Q value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (ld) begin
            r_q    <= w_load_val;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_tick <= 1'b1;
            if (up) begin
                r_wrap <= (r_q == c_MAX);
                r_q    <= (r_q == c_MAX) ? '0 : r_q + WIDTH'(1);
            end else begin
                r_wrap <= (r_q == '0);
                r_q    <= (r_q == '0) ? c_MAX : r_q - WIDTH'(1);
            end
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Qb   = ~r_q;
    assign tick = r_tick;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tick_nbit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_nbit_cnt
// Description : Self-checking bench for tick_nbit_cnt. It drives two
//               instances, (WIDTH=3, MODULUS=6, DIV=4) and
//               (WIDTH=1, MODULUS=2, DIV=1), from the same controls and
//               compares them every cycle against an arithmetic reference
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_nbit_cnt;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [2:0] d   = 3'd0;

    logic [2:0] q_a, qb_a;
    logic       tick_a, wrap_a;
    logic [0:0] q_b, qb_b;
    logic       tick_b, wrap_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks = 0;
    int n_wraps = 0;

    // Reference state: count value, enabled cycles since the last step or
    // restart, and the expected tick/wrap pulses.
    int m_qa = 0, m_pha = 0, m_qb = 0, m_phb = 0;
    bit e_ta = 0, e_wa = 0, e_tb = 0, e_wb = 0;

    tick_nbit_cnt #(.WIDTH(3), .MODULUS(6), .DIV(4)) dut_a (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .up  (up),
        .ld  (ld),
        .d   (d),
        .Q   (q_a),
        .Qb  (qb_a),
        .tick(tick_a),
        .wrap(wrap_a)
    );

    tick_nbit_cnt #(.WIDTH(1), .MODULUS(2), .DIV(1)) dut_b (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .up  (up),
        .ld  (ld),
        .d   (d[0:0]),
        .Q   (q_b),
        .Qb  (qb_b),
        .tick(tick_b),
        .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the counter rules to a reference state.
    task automatic model_edge(input int m, input int dv, input int dval,
                              inout int q, inout int ph, output bit tk, output bit wr);
        tk = 1'b0;
        wr = 1'b0;
        if (ld) begin
            q  = (dval >= m) ? m - 1 : dval;
            ph = 0;
        end else if (en) begin
            ph = ph + 1;
            if (ph == dv) begin
                ph = 0;
                tk = 1'b1;
                if (up) begin
                    wr = (q == m - 1);
                    q  = (q + 1) % m;
                end else begin
                    wr = (q == 0);
                    q  = (q + m - 1) % m;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_qa = 0; m_pha = 0; m_qb = 0; m_phb = 0;
        e_ta = 0; e_wa = 0; e_tb = 0; e_wb = 0;
    endtask

    task automatic check_all();
        logic [2:0] exp_qb_a;
        logic [0:0] exp_qb_b;
        exp_qb_a = ~3'(m_qa);
        exp_qb_b = ~1'(m_qb);
        chk("a_Q",    32'(q_a),    32'(m_qa));
        chk("a_Qb",   32'(qb_a),   32'(exp_qb_a));
        chk("a_tick", 32'(tick_a), 32'(e_ta));
        chk("a_wrap", 32'(wrap_a), 32'(e_wa));
        chk("b_Q",    32'(q_b),    32'(m_qb));
        chk("b_Qb",   32'(qb_b),   32'(exp_qb_b));
        chk("b_tick", 32'(tick_b), 32'(e_tb));
        chk("b_wrap", 32'(wrap_b), 32'(e_wb));
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // check the outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            model_edge(6, 4, int'(d),    m_qa, m_pha, e_ta, e_wa);
            model_edge(2, 1, int'(d[0]), m_qb, m_phb, e_tb, e_wb);
        end
        #1;
        if (tick_a) n_ticks++;
        if (wrap_a) n_wraps++;
        check_all();
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        // Reset state, then count up from reset for 28 clocks.
        #1;
        do_reset();
        en = 1'b1;
        up = 1'b1;
        n_ticks = 0;
        n_wraps = 0;
        repeat (28) cycle();
        chk("up_tick_count", 32'(n_ticks), 32'd7);
        chk("up_wrap_count", 32'(n_wraps), 32'd1);

        // Count down from reset: the first step wraps 0 -> 5.
        do_reset();
        up = 1'b0;
        repeat (4) cycle();
        chk("down_first_Q", 32'(q_a), 32'd5);
        chk("down_first_wrap", 32'(wrap_a), 32'd1);
        repeat (12) cycle();

        // Load mid-period, then load an out-of-range value.
        up = 1'b1;
        repeat (2) cycle();
        ld = 1'b1; d = 3'd3;
        cycle();
        ld = 1'b0;
        chk("load3_Q", 32'(q_a), 32'd3);
        repeat (3) cycle();
        chk("load3_no_early_tick", 32'(tick_a), 32'd0);
        cycle();
        chk("load3_step_Q", 32'(q_a), 32'd4);
        ld = 1'b1; d = 3'd7;
        cycle();
        ld = 1'b0;
        chk("load7_clamp_Q", 32'(q_a), 32'd5);
        repeat (4) cycle();

        // Pause the enable after two prescaler counts.
        ld = 1'b1; d = 3'd0;
        cycle();
        ld = 1'b0;
        repeat (2) cycle();
        en = 1'b0;
        repeat (10) cycle();
        chk("pause_hold_Q", 32'(q_a), 32'd0);
        en = 1'b1;
        repeat (2) cycle();
        chk("pause_resume_Q", 32'(q_a), 32'd1);
        repeat (4) cycle();

        // Asynchronous clear between edges with Q=4.
        do_reset();
        up = 1'b1;
        repeat (16) cycle();
        chk("preclr_Q", 32'(q_a), 32'd4);
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        clr = 1'b0;
        repeat (3) cycle();
        chk("postclr_no_tick", 32'(tick_a), 32'd0);
        cycle();
        chk("postclr_first_Q", 32'(q_a), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom);
            ld = ($urandom_range(0, 15) == 0);
            d  = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
